// File: rtl/crc16_pkg.sv
// crc16_pkg: shared types and constants for the serial CRC-16 checker/generator.
// Holds the checker state enum and the default polynomial / init values.
// Imported by crc16_serial_step and crc16_checker.
package crc16_pkg;

   localparam int              CRC_W              = 16;
   localparam logic [CRC_W-1:0] CRC16_POLY_DEFAULT = 16'h8005;
   localparam logic [CRC_W-1:0] CRC16_INIT_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      CRC  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/crc16_serial_step.sv
// crc16_serial_step: one-bit MSB-first CRC update, shared by checker and generator.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: crc_in (current register), bit_in (serial bit) -> crc_out (updated register).
module crc16_serial_step
   import crc16_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = CRC16_POLY_DEFAULT
) (
   input  logic [CRC_W-1:0] crc_in,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc_out
);

   logic fb;

   assign fb      = bit_in ^ crc_in[CRC_W-1];
   assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});

endmodule

// File: rtl/crc16_checker.sv
// crc16_checker: serial frame checker; CRC over frame_len payload bits, then compares 16 rx CRC bits.
// Latency: done pulses 1 cycle after the last valid CRC bit. Backpressure: none; bit_valid=0 is a bubble.
// Ports: clk/reset (sync, active-high), start+frame_len, bit_in+bit_valid in; busy, done, crc_ok, crc_err, calc_crc, rx_crc out.
module crc16_checker
   import crc16_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = CRC16_POLY_DEFAULT,
   parameter logic [CRC_W-1:0] INIT = CRC16_INIT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      frame_len,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             busy,
   output logic             done,
   output logic             crc_ok,
   output logic             crc_err,
   output logic [CRC_W-1:0] calc_crc,
   output logic [CRC_W-1:0] rx_crc
);

   state_t           state_q, state_d;
   logic [CRC_W-1:0] crc_q, crc_d;
   logic [CRC_W-1:0] rx_q, rx_d;
   logic [15:0]      bit_cnt_q, bit_cnt_d;
   logic [15:0]      len_q, len_d;
   logic [3:0]       crc_cnt_q, crc_cnt_d;
   logic             ok_q, ok_d;
   logic             res_vld_q, res_vld_d;

   logic [CRC_W-1:0] crc_step;
   logic [15:0]      bit_cnt_inc;

   crc16_serial_step #(
      .POLY (POLY)
   ) u_step (
      .crc_in  (crc_q),
      .bit_in  (bit_in),
      .crc_out (crc_step)
   );

   assign bit_cnt_inc = bit_cnt_q + 16'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      crc_d     = crc_q;
      rx_d      = rx_q;
      bit_cnt_d = bit_cnt_q;
      len_d     = len_q;
      crc_cnt_d = crc_cnt_q;
      ok_d      = ok_q;
      res_vld_d = res_vld_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               crc_d     = INIT;
               rx_d      = '0;
               bit_cnt_d = '0;
               crc_cnt_d = '0;
               len_d     = frame_len;
               ok_d      = 1'b0;
               res_vld_d = 1'b0;
               // An empty payload skips straight to collecting the CRC bits.
               state_d   = (frame_len == 16'd0) ? CRC : DATA;
            end
         end
         DATA: begin
            if (bit_valid) begin
               crc_d     = crc_step;
               bit_cnt_d = bit_cnt_inc;
               if (bit_cnt_inc == len_q) begin
                  state_d = CRC;
               end
            end
         end
         CRC: begin
            if (bit_valid) begin
               rx_d      = {rx_q[CRC_W-2:0], bit_in};
               crc_cnt_d = crc_cnt_q + 4'd1;
               if (crc_cnt_q == 4'd15) begin
                  state_d   = DONE;
                  // Compare against the value including this last bit, not the stale register.
                  ok_d      = (rx_d == crc_q);
                  res_vld_d = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crc_q     <= INIT;
         rx_q      <= '0;
         bit_cnt_q <= '0;
         len_q     <= '0;
         crc_cnt_q <= '0;
         ok_q      <= 1'b0;
         res_vld_q <= 1'b0;
      end else begin
         crc_q     <= crc_d;
         rx_q      <= rx_d;
         bit_cnt_q <= bit_cnt_d;
         len_q     <= len_d;
         crc_cnt_q <= crc_cnt_d;
         ok_q      <= ok_d;
         res_vld_q <= res_vld_d;
      end
   end

   assign busy     = (state_q == DATA) || (state_q == CRC);
   assign done     = (state_q == DONE);
   assign crc_ok   = res_vld_q & ok_q;
   assign crc_err  = res_vld_q & ~ok_q;
   assign calc_crc = crc_q;
   assign rx_crc   = rx_q;

endmodule
